// File: rtl/pi1_pkg.sv
// Shared PerInt definitions: op encodings and a constant-friendly clog2.
package pi1_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pi1_rrpick.sv
// Rotate-priority picker: first requester after i_cur (wrapping), i_cur itself last.
module pi1_rrpick
  import pi1_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_cur,
  output logic [IW-1:0] o_nxt,
  output logic          o_any
);

  // Walk distances from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_nxt = i_cur;
    o_any = |i_req;
    for (int d = N; d >= 1; d--) begin
      for (int j = 0; j < N; j++) begin
        if (i_req[j] && (j == ((int'(i_cur) + d) % N))) o_nxt = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pi1_rrarb.sv
// Round-robin PerInt arbiter: one slave shared by MASTERCOUNT masters with bounded
// bursts and routing of the single outstanding read back to its issuer.
module pi1_rrarb
  import pi1_pkg::*;
#(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 16,
  parameter int BURSTMAX    = 4,
  localparam int ADDRBITSZ  = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int SELW       = ARCHBITSZ / 8,
  localparam int GW         = clog2(MASTERCOUNT)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [2*MASTERCOUNT-1:0]         m_op_i_flat,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i_flat,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i_flat,
  output logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_o_flat,
  input  logic [SELW*MASTERCOUNT-1:0]      m_sel_i_flat,
  output logic [MASTERCOUNT-1:0]           m_rdy_o_flat,
  output logic [1:0]                      s_op_o,
  output logic [ADDRBITSZ-1:0]            s_addr_o,
  output logic [ARCHBITSZ-1:0]            s_data_o,
  output logic [SELW-1:0]                 s_sel_o,
  input  logic [ARCHBITSZ-1:0]            s_data_i,
  input  logic                            s_rdy_i,
  output logic [GW-1:0]                   gnt_o
);

  localparam int BW = clog2(BURSTMAX) + 1;
  localparam logic [BW-1:0] BLAST = BW'(BURSTMAX - 1);

  logic [1:0]           w_mop   [MASTERCOUNT];
  logic [ADDRBITSZ-1:0] w_maddr [MASTERCOUNT];
  logic [ARCHBITSZ-1:0] w_mdat  [MASTERCOUNT];
  logic [SELW-1:0]      w_msel  [MASTERCOUNT];
  logic [MASTERCOUNT-1:0] w_req;

  logic [GW-1:0]        r_gnt;
  logic [BW-1:0]        r_bcnt;
  logic                 r_pend;
  logic [GW-1:0]        r_pidx;
  logic                 r_prd;
  logic [ARCHBITSZ-1:0] r_mdato [MASTERCOUNT];

  logic          w_blocked;
  logic [1:0]    w_sop;
  logic          w_acc;
  logic          w_rot;
  logic [GW-1:0] w_nxt;
  logic          w_any;

  for (genvar gi = 0; gi < MASTERCOUNT; gi++) begin : g_port
    assign w_mop[gi]   = m_op_i_flat[2*gi +: 2];
    assign w_maddr[gi] = m_addr_i_flat[ADDRBITSZ*gi +: ADDRBITSZ];
    assign w_mdat[gi]  = m_data_i_flat[ARCHBITSZ*gi +: ARCHBITSZ];
    assign w_msel[gi]  = m_sel_i_flat[SELW*gi +: SELW];
    assign w_req[gi]   = (w_mop[gi] != PINOOP);
    assign m_data_o_flat[ARCHBITSZ*gi +: ARCHBITSZ] = r_mdato[gi];
    assign m_rdy_o_flat[gi] = (r_gnt == GW'(gi)) && s_rdy_i && !w_blocked;
  end

  // The granted master keeps the grant but is stalled while its own read is in flight.
  assign w_blocked = r_pend && r_prd && (r_pidx == r_gnt);
  assign w_sop     = w_blocked ? PINOOP : w_mop[r_gnt];
  assign w_acc     = s_rdy_i && (w_sop != PINOOP);
  assign w_rot     = (!w_blocked && (w_mop[r_gnt] == PINOOP)) ||
                     (w_acc && (r_bcnt == BLAST));

  assign s_op_o   = w_sop;
  assign s_addr_o = w_maddr[r_gnt];
  assign s_data_o = w_mdat[r_gnt];
  assign s_sel_o  = w_msel[r_gnt];
  assign gnt_o    = r_gnt;

  pi1_rrpick #(
    .N (MASTERCOUNT)
  ) u_pick (
    .i_req (w_req),
    .i_cur (r_gnt),
    .o_nxt (w_nxt),
    .o_any (w_any)
  );

  // Grant and burst counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gnt  <= '0;
      r_bcnt <= '0;
    end else if (w_rot) begin
      r_gnt  <= w_any ? w_nxt : r_gnt;
      r_bcnt <= '0;
    end else if (w_acc) begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  // Outstanding-op tracking; capture uses the previous pidx even when a new op issues.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= 1'b0;
      r_pidx <= '0;
      r_prd  <= 1'b0;
      for (int i = 0; i < MASTERCOUNT; i++) r_mdato[i] <= '0;
    end else if (s_rdy_i) begin
      if (r_pend && r_prd) r_mdato[r_pidx] <= s_data_i;
      r_pend <= w_acc;
      r_pidx <= r_gnt;
      r_prd  <= w_sop[1];
    end
  end

endmodule

// File: tb/tb_pi1_rrarb.sv
// Scoreboard bench for pi1_rrarb: expected slave acceptances and read returns are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_pi1_rrarb;
  import pi1_pkg::*;

  localparam int MC = 2;
  localparam int DW = 16;
  localparam int BM = 4;
  localparam int AW = DW - clog2(DW / 8);
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    mop   [MC];
  logic [AW-1:0] maddr [MC];
  logic [DW-1:0] mdat  [MC];
  logic [SW-1:0] msel  [MC];

  logic [2*MC-1:0]  m_op_flat;
  logic [AW*MC-1:0] m_addr_flat;
  logic [DW*MC-1:0] m_dati_flat;
  logic [SW*MC-1:0] m_sel_flat;
  logic [DW*MC-1:0] m_dato;
  logic [MC-1:0]    m_rdy;
  logic [1:0]       s_op;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_dato;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dati;
  logic             s_rdy;
  logic [0:0]       gnt;

  for (genvar g = 0; g < MC; g++) begin : g_flat
    assign m_op_flat[2*g +: 2]     = mop[g];
    assign m_addr_flat[AW*g +: AW] = maddr[g];
    assign m_dati_flat[DW*g +: DW] = mdat[g];
    assign m_sel_flat[SW*g +: SW]  = msel[g];
  end

  pi1_rrarb #(
    .MASTERCOUNT (MC),
    .ARCHBITSZ   (DW),
    .BURSTMAX    (BM)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_op_i_flat   (m_op_flat),
    .m_addr_i_flat (m_addr_flat),
    .m_data_i_flat (m_dati_flat),
    .m_data_o_flat (m_dato),
    .m_sel_i_flat  (m_sel_flat),
    .m_rdy_o_flat  (m_rdy),
    .s_op_o        (s_op),
    .s_addr_o      (s_addr),
    .s_data_o      (s_dato),
    .s_sel_o       (s_sel),
    .s_data_i      (s_dati),
    .s_rdy_i       (s_rdy),
    .gnt_o         (gnt)
  );

  // Slave model: small memory, read data registered on acceptance and held.
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (!rst && s_rdy && s_op != PINOOP) begin
      if (s_op[0]) mem[s_addr[7:0]] <= s_dato;
      if (s_op[1]) s_dati <= mem[s_addr[7:0]];
    end
  end

  typedef struct packed {
    logic          mst;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } acc_t;

  acc_t          expq[$];
  logic [DW-1:0] rdq0[$];
  logic [DW-1:0] rdq1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic issue(input int k, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] sel);
    bit done;
    done = 1'b0;
    mop[k] = op; maddr[k] = a; mdat[k] = d; msel[k] = sel;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (m_rdy[k]) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout master=%0d actual=not_accepted required=accepted", k);
    end
    mop[k] = PINOOP;
  endtask

  // Monitor: read-return check on the issuer's next rdy, then slave acceptance check.
  logic [MC-1:0] waitrd;
  initial begin
    acc_t e;
    waitrd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        waitrd = '0;
        rdq0.delete();
        rdq1.delete();
      end else begin
        for (int k = 0; k < MC; k++) begin
          if (waitrd[k] && m_rdy[k]) begin
            waitrd[k] = 1'b0;
            if (k == 0 && rdq0.size() != 0) chk("rdata_m0", m_dato[15:0], rdq0.pop_front());
            else if (k == 1 && rdq1.size() != 0) chk("rdata_m1", m_dato[31:16], rdq1.pop_front());
            else begin
              checks++; errors++;
              $display("FAIL rdata_unexpected master=%0d actual=%0h required=none", k, m_dato);
            end
          end
        end
        if (s_rdy && s_op != PINOOP) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL accept_unexpected actual=op%0h/m%0d required=none", s_op, gnt);
          end else begin
            e = expq.pop_front();
            chk("acc_mst", gnt, e.mst);
            chk("acc_op", s_op, e.op);
            chk("acc_addr", s_addr, e.addr);
            chk("acc_data", s_dato, e.data);
            chk("acc_sel", s_sel, e.sel);
            chk("acc_rdy", m_rdy[gnt], 1'b1);
            if (s_op[1]) waitrd[gnt] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MC; i++) begin
      mop[i] = PINOOP; maddr[i] = '0; mdat[i] = '0; msel[i] = '0;
    end
    s_rdy = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rdy", m_rdy, 2'b01);
    chk("rst_sop", s_op, PINOOP);
    chk("rst_mdat", m_dato, 0);
    @(posedge clk); #1;

    // Both masters write at once: M0 first, grant switch costs one idle cycle.
    expq.push_back('{1'b0, PIWROP, 15'h10, 16'hBEEF, 2'b11});
    expq.push_back('{1'b1, PIWROP, 15'h11, 16'hCAFE, 2'b01});
    fork
      issue(0, PIWROP, 15'h10, 16'hBEEF, 2'b11);
      issue(1, PIWROP, 15'h11, 16'hCAFE, 2'b01);
      begin
        @(negedge clk); chk("c0_sop", s_op, PIWROP); chk("c0_gnt", gnt, 0);
        @(negedge clk); chk("c1_gnt", gnt, 0); chk("c1_rdy", m_rdy, 2'b01);
        @(negedge clk); chk("c2_gnt", gnt, 1); chk("c2_rdy", m_rdy, 2'b10);
      end
    join

    // M1 write then read back 0x1234; one blocked cycle.
    expq.push_back('{1'b1, PIWROP, 15'h20, 16'h1234, 2'b11});
    expq.push_back('{1'b1, PIRDOP, 15'h20, 16'h0000, 2'b11});
    rdq1.push_back(16'h1234);
    issue(1, PIWROP, 15'h20, 16'h1234, 2'b11);
    issue(1, PIRDOP, 15'h20, 16'h0000, 2'b11);
    @(negedge clk); chk("rd_block_rdy", m_rdy[1], 1'b0); chk("rd_block_sop", s_op, PINOOP);
    @(negedge clk); chk("rd_unblock_rdy", m_rdy[1], 1'b1); chk("rd_data_m1", m_dato[31:16], 16'h1234);
    @(posedge clk); #1;

    // M0 read with slave stalled 5 cycles while M1 waits for the grant.
    expq.push_back('{1'b0, PIRDOP, 15'h10, 16'h0000, 2'b10});
    rdq0.push_back(16'hBEEF);
    issue(0, PIRDOP, 15'h10, 16'h0000, 2'b10);
    expq.push_back('{1'b1, PIWROP, 15'h30, 16'h5A5A, 2'b11});
    fork
      issue(1, PIWROP, 15'h30, 16'h5A5A, 2'b11);
      begin
        s_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_rdy", m_rdy, 2'b00);
          chk("stall_gnt", gnt, 0);
          chk("stall_sop", s_op, PINOOP);
          chk("stall_mdat0", m_dato[15:0], 16'h0000);
        end
        #1 s_rdy = 1'b1;
      end
    join
    @(posedge clk); #1;

    // Streaming writes from both masters: bursts of BM alternate, M1 holds the grant first.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BM; i++)
        expq.push_back('{1'b1, PIWROP, 15'(8'h50 + b*BM + i), 16'(16'hB000 + b*BM + i), 2'(i + 1)});
      for (int i = 0; i < BM; i++)
        expq.push_back('{1'b0, PIWROP, 15'(8'h40 + b*BM + i), 16'(16'hA000 + b*BM + i), 2'(i + 1)});
    end
    fork
      for (int i = 0; i < 2*BM; i++)
        issue(0, PIWROP, 15'(8'h40 + i), 16'(16'hA000 + i), 2'((i % BM) + 1));
      for (int i = 0; i < 2*BM; i++)
        issue(1, PIWROP, 15'(8'h50 + i), 16'(16'hB000 + i), 2'((i % BM) + 1));
    join
    @(posedge clk); #1;

    // Reset asserted while M1's read is outstanding.
    expq.push_back('{1'b1, PIRDOP, 15'h50, 16'h0000, 2'b11});
    issue(1, PIRDOP, 15'h50, 16'h0000, 2'b11);
    @(negedge clk);
    chk("prerst_gnt", gnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_rdy", m_rdy, 2'b01);
    chk("arst_sop", s_op, PINOOP);
    chk("arst_mdat", m_dato, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_mdat", m_dato, 0);
    end

    chk("expq_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
